// File: rtl/cpu_wb_pkg.sv
// rtl/cpu_wb_pkg.sv - shared types and widths for the register-file writeback queue
// Purpose: one writeback request (destination register + data) as a packed struct.
package cpu_wb_pkg;

  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 8;

  typedef struct packed {
    logic [2:0] reg_idx;
    logic [7:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular FIFO of writeback entries with per-slot valid bits
// Purpose: DEPTH-entry storage; exposes head, occupancy, read pointer and all
//          slots so the parent can scan pending writes in age order.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, push_entry_i   enqueue request (ignored when full)
//   pop_i             dequeue request (ignored when empty)
//   head_o            oldest entry
//   full_o, empty_o, count_o   occupancy
//   rd_ptr_o          physical slot of the oldest entry
//   entries_o, valid_o     raw slot contents and occupancy per slot
module wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [PTR_W-1:0]      rd_ptr_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]      valid_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // No pass-through when full: a push is refused even if a pop frees a slot.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    // Push and pop never target the same slot: that would need a full queue.
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset; valid_q qualifies every slot.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - arbitrated writeback queue in front of the register file
// Purpose: accepts one result per cycle (memory stage has priority over ALU),
//          drains one per cycle into the register file write port, and reports
//          pending writes (busy_mask) and the youngest pending value (fwd_*).
// Ports:
//   CLK, Reset                       clock, synchronous active-high reset
//   mem_valid/mem_reg/mem_data/mem_ready   memory-stage producer
//   alu_valid/alu_reg/alu_data/alu_ready   ALU producer
//   wb_stall                         hold the drain
//   regWrite/wrReg/writeValue        register file write port
//   lookup_reg/fwd_hit/fwd_value     forwarding query
//   busy_mask                        registers with queued writes
//   count                            occupied entries
module rf_writeback_queue
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREGS = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 wb_stall,
  output logic                 regWrite,
  output logic [REG_IDX_W-1:0] wrReg,
  output logic [DATA_W-1:0]    writeValue,
  input  logic [REG_IDX_W-1:0] lookup_reg,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_value,
  output logic [NREGS-1:0]     busy_mask,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full, empty, push;

  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);

  always_comb begin
    push_entry = '0;
    if (mem_valid) begin
      push_entry.reg_idx = mem_reg;
      push_entry.data    = mem_data;
    end else begin
      push_entry.reg_idx = alu_reg;
      push_entry.data    = alu_data;
    end
  end

  // Suppressed during Reset so a queue being discarded never writes the file.
  assign regWrite   = !empty && !wb_stall && !Reset;
  assign wrReg      = empty ? '0 : head.reg_idx;
  assign writeValue = empty ? '0 : head.data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (CLK),
    .rst_i        (Reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (regWrite),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .rd_ptr_o     (rd_ptr),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  // Walk oldest to youngest; a later match overwrites, so the youngest wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) &&
          (entries[PTR_W'(rd_ptr + PTR_W'(k))].reg_idx == lookup_reg)) begin
        fwd_hit   = 1'b1;
        fwd_value = entries[PTR_W'(rd_ptr + PTR_W'(k))].data;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        busy_mask[entries[i].reg_idx] = 1'b1;
      end
    end
  end

endmodule
